// File: rtl/i2c_mux_scheduler_if.sv
// Bus-side signal bundle for i2c_mux_scheduler.
// The slave modport is the scheduler's view; the master modport is the view of
// the requesters plus the IOBUF (which drives SDI_I2CS).
// Handshake: REQ_IN[i] is a level held for the whole access; the requester owns
// the bus pins while GRANT_OUT[i] is high and releases by dropping REQ_IN[i].
interface i2c_mux_scheduler_if;
    logic [3:0] REQ_IN;
    logic [3:0] GRANT_OUT;
    logic [3:0] REQ_SCL_IN;
    logic [3:0] REQ_SDO_IN;
    logic [3:0] REQ_SDT_IN;
    logic       I2C_SCLK;
    logic       SDO_I2CS;
    logic       SDI_I2CS;
    logic       SDT_I2CS;
    logic       BUSY_OUT;
    logic [3:0] ERR_OUT;
    logic [7:0] CUR_CH_OUT;
    logic [3:0] state_dbg;

    modport slave (
        input  REQ_IN, REQ_SCL_IN, REQ_SDO_IN, REQ_SDT_IN, SDI_I2CS,
        output GRANT_OUT, I2C_SCLK, SDO_I2CS, SDT_I2CS, BUSY_OUT, ERR_OUT,
               CUR_CH_OUT, state_dbg
    );

    modport master (
        output REQ_IN, REQ_SCL_IN, REQ_SDO_IN, REQ_SDT_IN, SDI_I2CS,
        input  GRANT_OUT, I2C_SCLK, SDO_I2CS, SDT_I2CS, BUSY_OUT, ERR_OUT,
               CUR_CH_OUT, state_dbg
    );
endinterface

// File: rtl/i2c_mux_scheduler.sv
// Round-robin scheduler sharing one I2C bus behind a PCA9548A switch among four
// requesters. For each grant it writes the requester's channel mask to the
// switch (retrying on NACK), then hands the bus pins to the requester.
// Optional macro CACHE_CHANNEL_EN: skip the switch write when the wanted mask
// is already the last mask ACKed by the switch.
module i2c_mux_scheduler #(
    parameter logic [8:0]  SYSCLK_FREQ_IN_MHz = 9'd200,
    parameter logic [9:0]  I2C_FREQ_KHZ       = 10'd100,
    parameter logic [6:0]  ADDR               = 7'd116,
    parameter logic [31:0] CH_MAP             = 32'h80400208,
    parameter logic [1:0]  MAX_RETRY          = 2'd3
) (
    input logic SYSCLK_IN,
    input logic RESET_N_IN,
    i2c_mux_scheduler_if.slave bus
);
    localparam int TICK_RAW = int'(SYSCLK_FREQ_IN_MHz) * 1000 / (4 * int'(I2C_FREQ_KHZ));
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_START, S_SEND, S_STOP, S_RETRY, S_GAP, S_GRANT
    } state_t;

    state_t      state_q, state_n, gap_to_q, gap_to_n;
    logic [15:0] tick_cnt;
    logic        tick;
    logic [1:0]  g_q, g_n, ptr_q, ptr_n, ph_q, ph_n, retry_q, retry_n;
    logic [4:0]  slot_q, slot_n;
    logic        nack_q, nack_n;
    logic [3:0]  err_q, err_set;
    logic [7:0]  cur_ch_q, cur_ch_n;
    logic        scl_q, sdo_q, sdt_q, scl_e, sdo_e, sdt_e;
    logic [3:0]  elig;
    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [7:0]  mask;
    logic [17:0] frame;
    logic        ack_slot;
`ifdef CACHE_CHANNEL_EN
    logic [7:0]  pick_mask;
    assign pick_mask = CH_MAP[{pick_idx, 3'b000} +: 8];
`endif

    assign elig     = bus.REQ_IN & ~err_q;
    assign mask     = CH_MAP[{g_q, 3'b000} +: 8];
    // Address byte (write), ACK slot, mask byte, ACK slot; ACK slots idle high.
    assign frame    = {ADDR, 1'b0, 1'b1, mask, 1'b1};
    assign ack_slot = (slot_q == 5'd8) || (slot_q == 5'd17);
    assign tick     = (tick_cnt == TICK_LAST);

    // Free-running quarter-bit tick divider.
    always_ff @(posedge SYSCLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN)  tick_cnt <= '0;
        else if (tick)    tick_cnt <= '0;
        else              tick_cnt <= tick_cnt + 16'd1;
    end

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (elig[ptr_q + 2'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 2'(i);
            end
        end
    end

    // Next-state logic and engine pin values for the switch-write sequence.
    always_comb begin
        state_n  = state_q;
        gap_to_n = gap_to_q;
        g_n      = g_q;
        ptr_n    = ptr_q;
        ph_n     = ph_q;
        slot_n   = slot_q;
        nack_n   = nack_q;
        retry_n  = retry_q;
        err_set  = '0;
        cur_ch_n = cur_ch_q;
        scl_e    = 1'b1;
        sdo_e    = 1'b1;
        sdt_e    = 1'b0;
        case (state_q)
            S_IDLE: if (|elig) state_n = S_ARB;
            S_ARB: begin
                if (!pick_found) begin
                    state_n = S_IDLE;
                end else begin
                    g_n     = pick_idx;
                    ptr_n   = pick_idx + 2'd1;
                    retry_n = 2'd0;
                    ph_n    = 2'd0;
`ifdef CACHE_CHANNEL_EN
                    if (pick_mask == cur_ch_q && cur_ch_q != 8'h00) state_n = S_GRANT;
                    else                                              state_n = S_START;
`else
                    state_n = S_START;
`endif
                end
            end
            S_START: begin
                scl_e = (ph_q != 2'd2);
                sdo_e = (ph_q == 2'd0);
                if (tick) begin
                    if (ph_q == 2'd2) begin
                        state_n = S_SEND;
                        ph_n    = 2'd0;
                        slot_n  = 5'd0;
                        nack_n  = 1'b0;
                    end else begin
                        ph_n = ph_q + 2'd1;
                    end
                end
            end
            S_SEND: begin
                scl_e = (ph_q == 2'd1) || (ph_q == 2'd2);
                sdt_e = ack_slot;
                sdo_e = ack_slot ? 1'b1 : frame[5'd17 - slot_q];
                if (tick) begin
                    if (ack_slot && ph_q == 2'd2 && bus.SDI_I2CS) nack_n = 1'b1;
                    ph_n = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        if (slot_q == 5'd17) state_n = S_STOP;
                        else                 slot_n  = slot_q + 5'd1;
                    end
                end
            end
            S_STOP: begin
                scl_e = (ph_q != 2'd0);
                sdo_e = (ph_q == 2'd2);
                if (tick) begin
                    if (ph_q == 2'd2) begin
                        ph_n = 2'd0;
                        if (nack_q) begin
                            state_n = S_RETRY;
                        end else begin
                            state_n  = S_GAP;
                            gap_to_n = S_GRANT;
                            cur_ch_n = mask;
                        end
                    end else begin
                        ph_n = ph_q + 2'd1;
                    end
                end
            end
            S_RETRY: begin
                if (retry_q < MAX_RETRY) begin
                    retry_n  = retry_q + 2'd1;
                    state_n  = S_GAP;
                    gap_to_n = S_START;
                    ph_n     = 2'd0;
                end else begin
                    err_set[g_q] = 1'b1;
                    cur_ch_n     = 8'h00;
                    state_n      = S_IDLE;
                end
            end
            S_GAP: begin
                if (tick) begin
                    ph_n = ph_q + 2'd1;
                    if (ph_q == 2'd3) state_n = gap_to_q;
                end
            end
            S_GRANT: begin
                if (!bus.REQ_IN[g_q]) begin
                    state_n  = S_GAP;
                    gap_to_n = S_IDLE;
                    ph_n     = 2'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, datapath and registered bus pins (requester pins while granted).
    always_ff @(posedge SYSCLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q  <= S_IDLE;
            gap_to_q <= S_IDLE;
            g_q      <= 2'd0;
            ptr_q    <= 2'd0;
            ph_q     <= 2'd0;
            slot_q   <= 5'd0;
            nack_q   <= 1'b0;
            retry_q  <= 2'd0;
            err_q    <= 4'd0;
            cur_ch_q <= 8'h00;
            scl_q    <= 1'b1;
            sdo_q    <= 1'b1;
            sdt_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            gap_to_q <= gap_to_n;
            g_q      <= g_n;
            ptr_q    <= ptr_n;
            ph_q     <= ph_n;
            slot_q   <= slot_n;
            nack_q   <= nack_n;
            retry_q  <= retry_n;
            err_q    <= (err_q & bus.REQ_IN) | err_set;
            cur_ch_q <= cur_ch_n;
            if (state_q == S_GRANT) begin
                scl_q <= bus.REQ_SCL_IN[g_q];
                sdo_q <= bus.REQ_SDO_IN[g_q];
                sdt_q <= bus.REQ_SDT_IN[g_q];
            end else begin
                scl_q <= scl_e;
                sdo_q <= sdo_e;
                sdt_q <= sdt_e;
            end
        end
    end

    assign bus.GRANT_OUT  = (state_q == S_GRANT) ? (4'b0001 << g_q) : 4'b0000;
    assign bus.BUSY_OUT   = (state_q != S_IDLE);
    assign bus.ERR_OUT    = err_q;
    assign bus.CUR_CH_OUT = cur_ch_q;
    assign bus.I2C_SCLK   = scl_q;
    assign bus.SDO_I2CS   = sdo_q;
    assign bus.SDT_I2CS   = sdt_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_i2c_mux_scheduler.sv
// Directed bench for i2c_mux_scheduler: a bus monitor decodes START/STOP and
// the 18 bit slots of each switch write, and a scoreboard compares each frame
// against hand-computed expected frames.
module tb_i2c_mux_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ack_line = 1'b0;
    logic mon_on = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0, stop_cnt = 0, bit_cnt = 0, grant_cnt = 0;
    logic [17:0] frame_cap = '0;
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    logic [17:0] exp_q[$];
    int s0, s1, p0, g0, n;

    i2c_mux_scheduler_if bif();

    i2c_mux_scheduler #(
        .SYSCLK_FREQ_IN_MHz(9'd8),
        .I2C_FREQ_KHZ(10'd1000)
    ) dut (
        .SYSCLK_IN(clk),
        .RESET_N_IN(rst_n),
        .bus(bif)
    );

    // Switch model: drives ack_line while the master releases SDA, else loops SDO back.
    assign bif.SDI_I2CS = bif.SDT_I2CS ? ack_line : bif.SDO_I2CS;

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] frame_of(input logic [7:0] m, input logic nk);
        return {8'hE8, nk, m, nk};
    endfunction

    // Bus monitor and scoreboard.
    always @(negedge clk) begin
        prev_scl <= bif.I2C_SCLK;
        prev_sda <= bif.SDI_I2CS;
        if (bif.GRANT_OUT != 4'b0000) grant_cnt <= grant_cnt + 1;
        if (rst_n && mon_on) begin
            if (prev_scl && bif.I2C_SCLK && prev_sda && !bif.SDI_I2CS) begin
                start_cnt <= start_cnt + 1;
                bit_cnt   <= 0;
            end else if (prev_scl && bif.I2C_SCLK && !prev_sda && bif.SDI_I2CS) begin
                stop_cnt <= stop_cnt + 1;
                check("frame_bits", bit_cnt, 18);
                if (exp_q.size() == 0) check("frame_extra", 1, 0);
                else                   check("frame", frame_cap, exp_q.pop_front());
            end else if (!prev_scl && bif.I2C_SCLK && bit_cnt < 18) begin
                frame_cap <= {frame_cap[16:0], bif.SDI_I2CS};
                bit_cnt   <= bit_cnt + 1;
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp, input int budget);
        int k = 0;
        while (bif.GRANT_OUT == 4'b0000 && k < budget) begin
            tick_clk();
            k++;
        end
        check(tag, bif.GRANT_OUT, exp);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (bif.BUSY_OUT && k < budget) begin
            tick_clk();
            k++;
        end
        check(tag, bif.BUSY_OUT, 0);
    endtask

    task automatic set_req_pins(input logic [3:0] scl, input logic [3:0] sdo, input logic [3:0] sdt);
        bif.REQ_SCL_IN = scl;
        bif.REQ_SDO_IN = sdo;
        bif.REQ_SDT_IN = sdt;
    endtask

    initial begin
        bif.REQ_IN = 4'b0000;
        set_req_pins(4'hF, 4'hF, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", bif.GRANT_OUT, 0);
        check("rst_scl", bif.I2C_SCLK, 1);
        check("rst_sdo", bif.SDO_I2CS, 1);
        check("rst_sdt", bif.SDT_I2CS, 0);
        check("rst_busy", bif.BUSY_OUT, 0);
        check("rst_err", bif.ERR_OUT, 0);
        check("rst_cur_ch", bif.CUR_CH_OUT, 0);
        rst_n = 1'b1;

        // Single requester, switch ACKs everything.
        exp_q.push_back(frame_of(8'h08, 1'b0));
        s0 = start_cnt;
        bif.REQ_IN = 4'b0001;
        wait_grant("t1_grant", 4'b0001, 1000);
        check("t1_cur_ch", bif.CUR_CH_OUT, 8'h08);
        check("t1_starts", start_cnt - s0, 1);
        check("t1_busy", bif.BUSY_OUT, 1);
        bif.REQ_IN = 4'b0000;
        tick_clk();
        check("t1_release", bif.GRANT_OUT, 0);
        wait_idle("t1_idle", 200);

        // Simultaneous requests right after reset: req1 then req2.
        apply_reset();
        exp_q.push_back(frame_of(8'h02, 1'b0));
        exp_q.push_back(frame_of(8'h40, 1'b0));
        bif.REQ_IN = 4'b0110;
        wait_grant("t2_grant1", 4'b0010, 1000);
        check("t2_cur_ch1", bif.CUR_CH_OUT, 8'h02);
        bif.REQ_IN = 4'b0100;
        tick_clk();
        wait_grant("t2_grant2", 4'b0100, 1000);
        check("t2_cur_ch2", bif.CUR_CH_OUT, 8'h40);
        bif.REQ_IN = 4'b0000;
        tick_clk();
        wait_idle("t2_idle", 200);

        // Pointer now at 3: req3 beats req0.
        exp_q.push_back(frame_of(8'h80, 1'b0));
        bif.REQ_IN = 4'b1001;
        wait_grant("ptr_grant", 4'b1000, 1000);
        bif.REQ_IN = 4'b1000;
        check("ptr_cur_ch", bif.CUR_CH_OUT, 8'h80);

        // Granted req3 drives the pins one clock later; others are ignored.
        mon_on = 1'b0;
        set_req_pins(4'b0111, 4'b0111, 4'b1000);
        #1;
        check("t4_scl_latency", bif.I2C_SCLK, 1);
        tick_clk();
        check("t4_scl", bif.I2C_SCLK, 0);
        check("t4_sdo", bif.SDO_I2CS, 0);
        check("t4_sdt", bif.SDT_I2CS, 1);
        set_req_pins(4'b1000, 4'b1000, 4'b0111);
        tick_clk();
        check("t4_scl_sel", bif.I2C_SCLK, 1);
        check("t4_sdo_sel", bif.SDO_I2CS, 1);
        check("t4_sdt_sel", bif.SDT_I2CS, 0);
        set_req_pins(4'hF, 4'hF, 4'h0);
        tick_clk();
        bif.REQ_IN = 4'b0000;
        tick_clk();
        wait_idle("t4_idle", 200);
        mon_on = 1'b1;

        // Switch NACKs: four attempts, then sticky error and no grant.
        ack_line = 1'b1;
        repeat (4) exp_q.push_back(frame_of(8'h08, 1'b1));
        s0 = start_cnt;
        p0 = stop_cnt;
        g0 = grant_cnt;
        bif.REQ_IN = 4'b0001;
        repeat (2) tick_clk();
        wait_idle("t3_idle", 3000);
        check("t3_starts", start_cnt - s0, 4);
        check("t3_stops", stop_cnt - p0, 4);
        check("t3_err", bif.ERR_OUT, 4'b0001);
        check("t3_no_grant", grant_cnt - g0, 0);
        check("t3_cur_ch", bif.CUR_CH_OUT, 0);
        repeat (3) tick_clk();
        check("t3_stays_idle", bif.BUSY_OUT, 0);
        bif.REQ_IN = 4'b0000;
        tick_clk();
        check("t3_err_clear", bif.ERR_OUT, 0);
        ack_line = 1'b0;

        // Back-to-back req0.
        exp_q.push_back(frame_of(8'h08, 1'b0));
        bif.REQ_IN = 4'b0001;
        wait_grant("t5_grant1", 4'b0001, 1000);
        bif.REQ_IN = 4'b0000;
        tick_clk();
        check("t5_drop", bif.GRANT_OUT, 0);
        bif.REQ_IN = 4'b0001;
        s1 = start_cnt;
`ifdef CACHE_CHANNEL_EN
        wait_grant("t5_grant2", 4'b0001, 20);
        check("t5_no_write", start_cnt - s1, 0);
`else
        exp_q.push_back(frame_of(8'h08, 1'b0));
        wait_grant("t5_grant2", 4'b0001, 1000);
        check("t5_rewrite", start_cnt - s1, 1);
`endif
        check("t5_cur_ch", bif.CUR_CH_OUT, 8'h08);
        bif.REQ_IN = 4'b0000;
        tick_clk();
        wait_idle("t5_idle", 200);

        // Asynchronous reset during the data byte, then a clean restart.
        exp_q.push_back(frame_of(8'h08, 1'b0));
        s0 = start_cnt;
        bif.REQ_IN = 4'b0001;
        n = 0;
        while (!(start_cnt > s0 && bit_cnt >= 12) && n < 1000) begin
            tick_clk();
            n++;
        end
        check("t6_in_data", (start_cnt > s0 && bit_cnt >= 12), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_scl", bif.I2C_SCLK, 1);
        check("t6_sdo", bif.SDO_I2CS, 1);
        check("t6_sdt", bif.SDT_I2CS, 0);
        check("t6_grant", bif.GRANT_OUT, 0);
        check("t6_cur_ch", bif.CUR_CH_OUT, 0);
        check("t6_busy", bif.BUSY_OUT, 0);
        repeat (3) tick_clk();
        rst_n = 1'b1;
        s1 = start_cnt;
        wait_grant("t6_regrant", 4'b0001, 1000);
        check("t6_restart", start_cnt - s1, 1);
        check("t6_cur_ch_after", bif.CUR_CH_OUT, 8'h08);
        bif.REQ_IN = 4'b0000;
        tick_clk();
        wait_idle("t6_idle", 200);

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
